// File: rtl/apb_wait_mem.sv
// APB3 slave memory with per-transfer wait states taken from PWAIT.
// Flags out-of-range accesses on PSLVERR and keeps a sticky protocol-violation flag.
module apb_wait_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT_W = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [WAIT_W-1:0] PWAIT,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              proto_err,
  output logic [15:0]       xfer_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              do_setup, do_complete, do_viol;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Handshake outputs come from registered state only.
  assign PREADY  = (state == ACCESS) && (cnt == '0);
  assign PSLVERR = PREADY && !in_range(addr_q);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    do_setup    = 1'b0;
    do_complete = 1'b0;
    do_viol     = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL) begin
          if (!PENABLE) do_setup = 1'b1;
          else          do_viol  = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          do_viol   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!PENABLE) begin
          // A fresh setup while a transfer is pending restarts cleanly.
          do_viol  = 1'b1;
          do_setup = 1'b1;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - WAIT_W'(1);
        end else begin
          do_complete = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (do_setup) begin
      state_nxt = ACCESS;
      cnt_nxt   = PWAIT;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      PRDATA     <= '0;
      proto_err  <= 1'b0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_viol)     proto_err  <= 1'b1;
      if (do_complete) xfer_count <= sat_inc(xfer_count);
      if (do_setup && !PWRITE)
        PRDATA <= in_range(PADDR) ? mem[word_idx(PADDR)] : '0;
    end
  end

  // Latched transfer attributes and storage carry no reset.
  always_ff @(posedge PCLK) begin
    if (do_setup) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
    end
    if (do_complete && write_q && in_range(addr_q))
      mem[word_idx(addr_q)] <= PWDATA;
  end

endmodule

// File: tb/tb_apb_wait_mem.sv
// Directed bench for apb_wait_mem: table of transfers plus hand-written
// abort, reset, protocol-violation and back-to-back sequences.
module tb_apb_wait_mem;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PWAIT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, proto_err;
  logic [15:0] xfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  apb_wait_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_W(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PWAIT(PWAIT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .proto_err(proto_err), .xfer_count(xfer_count)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  wt;
    logic [31:0] rd;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the completion edge.
  task automatic do_xfer(input logic w, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] wt, input logic [31:0] exp_rd, input logic exp_err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = ~wd; PWAIT = wt;
    @(negedge PCLK);
    PENABLE = 1'b1;
    PWRITE  = ~w;
    PADDR   = ~a;
    PWAIT   = ~wt;
    for (int i = 0; i <= int'(wt); i++) begin
      PWDATA = (i == int'(wt)) ? wd : ~wd;
      chk("pready", {31'b0, PREADY}, {31'b0, (i == int'(wt))});
      if (i == int'(wt)) begin
        chk("pslverr", {31'b0, PSLVERR}, {31'b0, exp_err});
        if (!w) chk("prdata", PRDATA, exp_rd);
      end
      @(negedge PCLK);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'd0,  32'h0,        1'b0, 16'd1};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        4'd0,  32'hDEADBEEF, 1'b0, 16'd2};
    vecs[2] = '{1'b1, 8'h3F, 32'h12345678, 4'd5,  32'h0,        1'b0, 16'd3};
    vecs[3] = '{1'b0, 8'h3F, 32'h0,        4'd15, 32'h12345678, 1'b0, 16'd4};
    vecs[4] = '{1'b1, 8'h80, 32'hFFFFFFFF, 4'd0,  32'h0,        1'b1, 16'd5};
    vecs[5] = '{1'b0, 8'h80, 32'h0,        4'd0,  32'h0,        1'b1, 16'd6};
    vecs[6] = '{1'b1, 8'h20, 32'h11111111, 4'd2,  32'h0,        1'b0, 16'd7};

    PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PWAIT = 0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_proto", {31'b0, proto_err}, 32'd0);
    chk("rst_count", {16'b0, xfer_count}, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    for (int v = 0; v < 7; v++) begin
      do_xfer(vecs[v].w, vecs[v].a, vecs[v].wd, vecs[v].wt, vecs[v].rd, vecs[v].err);
      chk("count", {16'b0, xfer_count}, {16'b0, vecs[v].cnt});
      chk("proto_clean", {31'b0, proto_err}, 32'd0);
      @(negedge PCLK);
    end

    // Abort a PWAIT=3 write by dropping PSEL during the wait phase.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h20; PWDATA = 32'hA5A5A5A5; PWAIT = 4'd3;
    @(negedge PCLK);
    PENABLE = 1;
    chk("abort_wait", {31'b0, PREADY}, 32'd0);
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0;
    @(negedge PCLK);
    chk("abort_proto", {31'b0, proto_err}, 32'd1);
    chk("abort_pready", {31'b0, PREADY}, 32'd0);
    chk("abort_count", {16'b0, xfer_count}, 32'd7);
    do_xfer(1'b0, 8'h20, 32'h0, 4'd0, 32'h11111111, 1'b0);
    chk("abort_rd_count", {16'b0, xfer_count}, 32'd8);

    // Asynchronous reset in the middle of a PWAIT=7 write.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h20; PWDATA = 32'hCAFEF00D; PWAIT = 4'd7;
    @(negedge PCLK);
    PENABLE = 1;
    @(negedge PCLK);
    @(negedge PCLK);
    #2 PRESET = 1'b1; PSEL = 0; PENABLE = 0;
    #1;
    chk("arst_pready", {31'b0, PREADY}, 32'd0);
    chk("arst_prdata", PRDATA, 32'd0);
    chk("arst_proto", {31'b0, proto_err}, 32'd0);
    chk("arst_count", {16'b0, xfer_count}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    do_xfer(1'b0, 8'h20, 32'h0, 4'd0, 32'h11111111, 1'b0);
    chk("arst_after_count", {16'b0, xfer_count}, 32'd1);

    // Access phase from IDLE without a setup.
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 8'h05; PWAIT = 0;
    @(negedge PCLK);
    chk("nosetup_pready", {31'b0, PREADY}, 32'd0);
    chk("nosetup_proto", {31'b0, proto_err}, 32'd1);
    @(negedge PCLK);
    chk("nosetup_pready2", {31'b0, PREADY}, 32'd0);
    chk("nosetup_count", {16'b0, xfer_count}, 32'd1);
    PSEL = 0; PENABLE = 0;
    @(negedge PCLK);

    // Back-to-back zero-wait writes, then read both back.
    do_xfer(1'b1, 8'h01, 32'h01010101, 4'd0, 32'h0, 1'b0);
    do_xfer(1'b1, 8'h02, 32'h02020202, 4'd0, 32'h0, 1'b0);
    chk("b2b_count", {16'b0, xfer_count}, 32'd3);
    do_xfer(1'b0, 8'h01, 32'h0, 4'd0, 32'h01010101, 1'b0);
    do_xfer(1'b0, 8'h02, 32'h0, 4'd0, 32'h02020202, 1'b0);
    chk("b2b_rd_count", {16'b0, xfer_count}, 32'd5);

    // Re-setup during ACCESS: the new read setup is taken, the write is dropped.
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("rst2_proto", {31'b0, proto_err}, 32'd0);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h30; PWDATA = 32'h0BADF00D; PWAIT = 4'd4;
    @(negedge PCLK);
    PENABLE = 1;
    @(negedge PCLK);
    do_xfer(1'b0, 8'h10, 32'h0, 4'd1, 32'hDEADBEEF, 1'b0);
    chk("resetup_proto", {31'b0, proto_err}, 32'd1);
    chk("resetup_count", {16'b0, xfer_count}, 32'd1);
    @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_wait_mem.md
Name: apb_wait_mem

Overview:
- APB3 slave memory that consumes the transfers produced by the team's APB master bus model.
- Decodes SETUP/ACCESS phases, inserts a per-transfer number of wait states taken from PWAIT, performs 32-bit reads and writes, and flags out-of-range accesses and protocol violations.
- Sits directly downstream of the master on the shared PCLK domain as the memory target for directed bus tests.

Parameters:
ADDR_W, 8, width of PADDR
DATA_W, 32, width of PWDATA/PRDATA
DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range
WAIT_W, 4, width of PWAIT and of the wait counter

Ports:
PCLK  input  1  clock, all state updates on the rising edge
PRESET  input  1  asynchronous, active-high reset
PSEL  input  1  slave select
PENABLE  input  1  access-phase strobe
PWRITE  input  1  1=write, 0=read
PADDR  input  ADDR_W  word address
PWDATA  input  DATA_W  write data
PWAIT  input  WAIT_W  wait states requested for this transfer
PRDATA  output  DATA_W  read data, valid while PREADY=1 on a read
PREADY  output  1  transfer completes on an edge where PREADY=1
PSLVERR  output  1  error response, valid only while PREADY=1
proto_err  output  1  sticky protocol-violation flag
xfer_count  output  16  count of completed transfers, including errored ones

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is asynchronous and active-high.
- Reset values while PRESET=1:
  - state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0, proto_err=0, xfer_count=0.
  - Memory array is not cleared; unwritten words read as X.
- States:
  - IDLE:
    - Edge with PSEL=1 and PENABLE=0 is a setup. It latches PADDR and PWRITE, loads the counter with PWAIT, and goes to ACCESS.
    - On a read setup, PRDATA <= mem[PADDR], or 0 if out of range.
  - ACCESS:
    - PREADY = (counter==0). This is decoded from registers only, with no combinational path from inputs.
    - PSLVERR = PREADY and latched address >= DEPTH.
    - Edge with PSEL=1, PENABLE=1, counter!=0: counter decrements.
    - Edge with PSEL=1, PENABLE=1, counter==0: transfer completes.
      - On a write, mem[addr] <= PWDATA sampled on this edge; suppressed if out of range.
      - xfer_count increments, saturating at 16'hFFFF.
      - Next state is IDLE.
    - Edge with PSEL=0: transfer aborted. Return to IDLE with no write and no count increment; proto_err <= 1.
    - Edge with PSEL=1, PENABLE=0: counts as a re-setup without completion. proto_err <= 1, and the new setup is taken exactly as from IDLE.
- Latency: PWAIT=N gives N cycles of PREADY=0 followed by one cycle of PREADY=1. The access phase lasts N+1 cycles, so PWAIT=0 is a zero-wait transfer.
- PRDATA holds its value until the next read setup or reset. It is not changed by writes or by the completion edge.
- IDLE edge with PSEL=1 and PENABLE=1 (access without setup): ignored, PREADY stays 0, proto_err <= 1.
- proto_err clears only on reset.
- PWAIT, PWRITE and PADDR changes during ACCESS are ignored; the values latched at setup apply.
- Back-to-back transfers: a setup in the cycle immediately after completion is accepted, giving minimum 2 cycles per transfer.
- Reset asserted mid-ACCESS: immediate return to IDLE with PREADY=0 and no memory write.

Test Plan:
- Write 0xDEADBEEF to 0x10 with PWAIT=0, then read 0x10 with PWAIT=0 -> PREADY high in the first access cycle of each transfer; PRDATA=0xDEADBEEF; xfer_count=2; PSLVERR=0.
- Write 0x12345678 to 0x3F with PWAIT=5 -> PREADY low for exactly 5 access cycles, high on the 6th; mem[0x3F] written only on the completion edge. A read with PWAIT=15 returns 0x12345678 after 15 wait cycles.
- Set DEPTH=128 and write 0xFFFFFFFF to 0x80 -> PSLVERR=1 with PREADY; a following read of 0x80 gives PRDATA=0, PSLVERR=1; xfer_count still increments.
- Drop PSEL during the wait phase of a PWAIT=3 write of 0xA5A5A5A5 to 0x20 -> return to IDLE, proto_err=1, mem[0x20] keeps its old value, xfer_count unchanged.
- Assert PRESET asynchronously mid-ACCESS of a PWAIT=7 write -> PREADY, PRDATA, proto_err and xfer_count are 0 immediately; no write occurs; the next PWAIT=0 transfer completes normally.
- Drive PSEL=1, PENABLE=1 from IDLE with no setup -> PREADY stays 0 and proto_err=1. Then run back-to-back writes to 0x01 and 0x02 -> each completes in 2 cycles.
